// File: rtl/rx_byte_queue.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_queue
// Description : Filtered, buffered byte stream between uart_rx and the
//               terminal FSM. Strips ANSI escape / CSI sequences, collapses
//               CR+LF into CR, and queues the surviving bytes in a FIFO with
//               a show-ahead valid/ready output.
// Ports       : clk          - pixel clock (pclk), rising edge
//               rst_n        - asynchronous active-low reset
//               in_data      - byte from uart_rx
//               in_valid     - one-cycle strobe qualifying in_data
//               flush        - synchronous clear of FIFO and filter state
//               out_data     - head-of-queue byte (0 when empty)
//               out_valid    - queue non-empty
//               out_ready    - consumer pops head when out_valid
//               level        - entry count, 0..DEPTH
//               overflow     - sticky: a filtered byte was dropped (full)
//               clr_overflow - synchronous clear of overflow
// Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_queue #(
    parameter int DEPTH   = 16,
    parameter int MAX_CSI = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam int c_CNT_W  = $clog2(MAX_CSI) + 1;

    localparam logic [7:0] c_ESC = 8'h1B;
    localparam logic [7:0] c_LSB = 8'h5B;
    localparam logic [7:0] c_CR  = 8'h0D;
    localparam logic [7:0] c_LF  = 8'h0A;

    typedef enum logic [1:0] {
        F_NORM = 2'd0,
        F_ESC  = 2'd1,
        F_CSI  = 2'd2
    } filt_state_t;

    // ------------------------------------------------------------------
    // Filter
    // ------------------------------------------------------------------
    filt_state_t          r_state;
    filt_state_t          w_state_nxt;
    logic                 r_cr_seen;
    logic                 w_cr_nxt;
    logic [c_CNT_W-1:0]   r_csi_cnt;
    logic [c_CNT_W-1:0]   w_csi_nxt;
    logic [c_CNT_W-1:0]   w_csi_inc;
    logic                 w_emit;

    assign w_csi_inc = r_csi_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cr_nxt    = r_cr_seen;
        w_csi_nxt   = r_csi_cnt;
        w_emit      = 1'b0;
        if (in_valid) begin
            case (r_state)
                F_NORM: begin
                    // Tracks only the previous byte seen in F_NORM; an ESC
                    // therefore clears it on the way out.
                    w_cr_nxt = (in_data == c_CR);
                    if (in_data == c_ESC) begin
                        w_state_nxt = F_ESC;
                    end else if (!(in_data == c_LF && r_cr_seen)) begin
                        w_emit = 1'b1;
                    end
                end
                F_ESC: begin
                    if (in_data == c_LSB) begin
                        w_state_nxt = F_CSI;
                        w_csi_nxt   = '0;
                    end else begin
                        w_state_nxt = F_NORM;
                    end
                end
                F_CSI: begin
                    if (in_data >= 8'h40 && in_data <= 8'h7E) begin
                        w_state_nxt = F_NORM;
                    end else begin
                        w_csi_nxt = w_csi_inc;
                        // Runaway sequence: give up after MAX_CSI parameter bytes
                        if (w_csi_inc == c_CNT_W'(MAX_CSI)) begin
                            w_state_nxt = F_NORM;
                        end
                    end
                end
                default: begin
                    w_state_nxt = F_NORM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= F_NORM;
            r_cr_seen <= 1'b0;
            r_csi_cnt <= '0;
        end else if (flush) begin
            r_state   <= F_NORM;
            r_cr_seen <= 1'b0;
            r_csi_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cr_seen <= w_cr_nxt;
            r_csi_cnt <= w_csi_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]           r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_overflow;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_drop;

    assign w_full = (r_level == c_LVL_W'(DEPTH));
    // Push and pop are both suppressed during flush so the flush cycle
    // leaves the queue empty regardless of other traffic.
    assign w_pop  = out_valid && out_ready && !flush;
    assign w_wr   = w_emit && (!w_full || w_pop) && !flush;
    assign w_drop = w_emit && w_full && !w_pop && !flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + c_LVL_W'(w_wr) - c_LVL_W'(w_pop);
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign out_valid = (r_level != '0);
    // Gated so the output reads zero after reset/flush even though the
    // storage array itself is not reset.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_byte_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_byte_queue
// Description : Self-checking bench for rx_byte_queue: a vector table for
//               single-cycle behaviour plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_byte_queue;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow;

    int errors = 0;
    int checks = 0;

    rx_byte_queue #(.DEPTH(DEPTH), .MAX_CSI(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       fl;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] el;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic iv, input logic [7:0] d,
                       input logic rdy, input logic fl, input logic clr,
                       input logic ev, input logic [7:0] ed, input logic [4:0] el,
                       input logic eo);
        vec_t v;
        v.nm = nm; v.iv = iv; v.d = d; v.rdy = rdy; v.fl = fl; v.clr = clr;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input logic iv, input logic [7:0] d, input logic rdy,
                        input logic fl, input logic clr);
        in_valid = iv; in_data = d; out_ready = rdy; flush = fl; clr_overflow = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk(nm, {24'h0, out_data}, {24'h0, exp});
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] tail [5];

        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;

        //      name         iv  data   rdy fl clr  ev  edata  lvl ovf
        // CR+LF collapse while consuming
        add("crlf_l",      1, 8'h6C, 1, 0, 0,   1, 8'h6C, 1, 0);
        add("crlf_s",      1, 8'h73, 1, 0, 0,   1, 8'h73, 1, 0);
        add("crlf_cr",     1, 8'h0D, 1, 0, 0,   1, 8'h0D, 1, 0);
        add("crlf_lf",     1, 8'h0A, 1, 0, 0,   0, 8'h00, 0, 0);
        add("empty_pop",   0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0);
        // ESC [ 1 ; 3 2 m A  -> only 'A'
        add("csi_esc",     1, 8'h1B, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_lsb",     1, 8'h5B, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_1",       1, 8'h31, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_semi",    1, 8'h3B, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_3",       1, 8'h33, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_2",       1, 8'h32, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_m",       1, 8'h6D, 0, 0, 0,   0, 8'h00, 0, 0);
        add("csi_A",       1, 8'h41, 0, 0, 0,   1, 8'h41, 1, 0);
        add("csi_popA",    0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0);
        // Lone ESC + other byte: both dropped
        add("esc_x",       1, 8'h1B, 0, 0, 0,   0, 8'h00, 0, 0);
        add("esc_other",   1, 8'h51, 0, 0, 0,   0, 8'h00, 0, 0);
        add("lf_alone",    1, 8'h0A, 0, 0, 0,   1, 8'h0A, 1, 0);
        // Flush resets filter state and discards that cycle's push
        add("fl_q",        1, 8'h71, 0, 0, 0,   1, 8'h0A, 2, 0);
        add("fl_esc",      1, 8'h1B, 0, 0, 0,   1, 8'h0A, 2, 0);
        add("fl_flush",    1, 8'h5B, 1, 1, 0,   0, 8'h00, 0, 0);
        add("fl_lsb_norm", 1, 8'h5B, 0, 0, 0,   1, 8'h5B, 1, 0);
        add("fl_cr",       1, 8'h0D, 0, 0, 0,   1, 8'h5B, 2, 0);
        add("fl_flush2",   0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0);
        add("fl_lf_pass",  1, 8'h0A, 0, 0, 0,   1, 8'h0A, 1, 0);
        add("fl_pop",      0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", {27'h0, level}, 32'd0);
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_data",  {24'h0, out_data}, 32'd0);
        chk("rst_ovf",   {31'h0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
            chk({tbl[i].nm, "_valid"}, {31'h0, out_valid}, {31'h0, tbl[i].ev});
            chk({tbl[i].nm, "_data"},  {24'h0, out_data},  {24'h0, tbl[i].ed});
            chk({tbl[i].nm, "_level"}, {27'h0, level},     {27'h0, tbl[i].el});
            chk({tbl[i].nm, "_ovf"},   {31'h0, overflow},  {31'h0, tbl[i].eo});
        end

        // Overflow: DEPTH+3 pushes without popping
        for (int i = 0; i < DEPTH + 3; i++) push(8'h30 + 8'(i));
        chk("ovf_level", {27'h0, level}, 32'd16);
        chk("ovf_flag",  {31'h0, overflow}, 32'd1);
        chk("ovf_head",  {24'h0, out_data}, 32'h30);
        // Drop while clearing: set wins
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", {31'h0, overflow}, 32'd1);
        chk("ovf_set_level", {27'h0, level}, 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear", {31'h0, overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_chk("ovf_order", 8'h30 + 8'(i));
        chk("ovf_drained", {27'h0, level}, 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
        chk("pp_full", {27'h0, level}, 32'd16);
        step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
        chk("pp_level", {27'h0, level}, 32'd16);
        chk("pp_ovf",   {31'h0, overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_chk("pp_order", 8'h41 + 8'(i));
        chk("pp_drained", {27'h0, level}, 32'd0);

        // Runaway CSI: first 16 parameter bytes dropped, rest pass
        push(8'h1B);
        push(8'h5B);
        for (int i = 0; i < 20; i++) push(8'h30 + 8'(i % 10));
        push(8'h5A);
        chk("csi_max_level", {27'h0, level}, 32'd5);
        tail[0] = 8'h36; tail[1] = 8'h37; tail[2] = 8'h38; tail[3] = 8'h39; tail[4] = 8'h5A;
        for (int i = 0; i < 5; i++) pop_chk("csi_max_order", tail[i]);

        // Asynchronous reset mid-CSI with data queued
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        push(8'h1B);
        push(8'h5B);
        push(8'h31);
        chk("ar_pre_level", {27'h0, level}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", {27'h0, level}, 32'd0);
        chk("ar_valid", {31'h0, out_valid}, 32'd0);
        chk("ar_data",  {24'h0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'h78);
        chk("ar_x_data",  {24'h0, out_data}, 32'h78);
        chk("ar_x_level", {27'h0, level}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
